// File: rtl/pipe_reg_file.sv
// pipe_reg_file: parametrised register file for the pipelined datapath.
// Combinational multi-port reads, one writeback port, and a per-register
// busy scoreboard with a registered count of busy registers. Register 0
// always reads as zero and is never marked busy.
// Optional feature: define PIPE_REG_FILE_BYPASS_EN to forward the writeback
// data (and its cleared busy bit) to matching read ports in the same cycle.
module pipe_reg_file #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
   output logic [NUM_RD*WIDTH-1:0]  rdData,
   output logic [NUM_RD-1:0]        rdBusy,
   input  logic                     wrEn,
   input  logic [ADDR_W-1:0]        wrAddr,
   input  logic [WIDTH-1:0]         wrData,
   input  logic                     issueEn,
   input  logic [ADDR_W-1:0]        issueAddr,
   output logic [ADDR_W:0]          busyCnt,
   output logic                     anyBusy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;
   logic [ADDR_W:0]  busy_cnt;
   logic             wr_hit;
   logic             issue_hit;
   logic             cnt_inc;
   logic             cnt_dec;

   // Address 0 is excluded from both writeback and reservation.
   assign wr_hit    = wrEn && (wrAddr != '0);
   assign issue_hit = issueEn && (issueAddr != '0);

   // Register storage: written from writeback only, cleared asynchronously.
   // NOTE: the whole array is reset because the register file must read
   // all-zero immediately on reset; this prevents mapping it onto RAM macros.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      end else if (wr_hit) begin
         regs[wrAddr] <= wrData;
      end
   end

   // Next busy vector and counter adjustment; a same-edge issue overrides the clear.
   // NOTE: combinational blocks use blocking assignments and give every output
   // a default first so no latch is inferred.
   always_comb begin
      busy_next = busy;
      cnt_inc   = 1'b0;
      cnt_dec   = 1'b0;
      if (wr_hit) begin
         busy_next[wrAddr] = 1'b0;
      end
      if (issue_hit) begin
         busy_next[issueAddr] = 1'b1;
      end
      cnt_inc = issue_hit && !busy[issueAddr];
      cnt_dec = wr_hit && busy[wrAddr] && !(issue_hit && (issueAddr == wrAddr));
   end

   // Busy scoreboard and its population count advance together on each edge.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= busy_cnt + (ADDR_W + 1)'(cnt_inc) - (ADDR_W + 1)'(cnt_dec);
      end
   end

   assign busyCnt = busy_cnt;
   assign anyBusy = (busy_cnt != '0);

   // Independent combinational read ports.
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  data;
      logic              bsy;

      assign addr = rdAddr[g*ADDR_W +: ADDR_W];

      // Select stored state, optionally forward writeback, then force address 0 to zero.
      always_comb begin
         data = regs[addr];
         bsy  = busy[addr];
`ifdef PIPE_REG_FILE_BYPASS_EN
         if (rstN && wr_hit && (addr == wrAddr)) begin
            data = wrData;
            bsy  = issue_hit && (issueAddr == wrAddr);
         end
`endif
         if (addr == '0) begin
            data = '0;
            bsy  = 1'b0;
         end
      end

      assign rdData[g*WIDTH +: WIDTH] = data;
      assign rdBusy[g]                = bsy;
   end

endmodule

// File: tb/tb_pipe_reg_file.sv
// tb_pipe_reg_file: directed scenarios with literal expectations plus a
// randomized run, all compared against a behavioural register-file model.
// Build with PIPE_REG_FILE_BYPASS_EN defined to check the bypass variant.
module tb_pipe_reg_file;

   localparam int W     = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 2 ** AW;

   logic              clk = 1'b0;
   logic              rstN;
   logic [NR*AW-1:0]  rdAddr;
   logic [NR*W-1:0]   rdData;
   logic [NR-1:0]     rdBusy;
   logic              wrEn;
   logic [AW-1:0]     wrAddr;
   logic [W-1:0]      wrData;
   logic              issueEn;
   logic [AW-1:0]     issueAddr;
   logic [AW:0]       busyCnt;
   logic              anyBusy;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   // Behavioural model: plain arrays of register values and busy flags.
   logic [W-1:0] m_reg  [DEPTH];
   bit           m_busy [DEPTH];

   pipe_reg_file #(.WIDTH(W), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk(clk), .rstN(rstN), .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .issueEn(issueEn), .issueAddr(issueAddr),
      .busyCnt(busyCnt), .anyBusy(anyBusy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int r = 0; r < DEPTH; r++) n += int'(m_busy[r]);
      return n;
   endfunction

   // Model update: writeback stores data and retires the reservation, then
   // issue reserves, so a same-edge issue to the same register leaves it busy.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int r = 0; r < DEPTH; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
         end
      end else begin
         if (wrEn && wrAddr != 0) begin
            m_reg[wrAddr]  = wrData;
            m_busy[wrAddr] = 1'b0;
         end
         if (issueEn && issueAddr != 0) m_busy[issueAddr] = 1'b1;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            logic [W-1:0]  ed;
            bit            eb;
            a  = rdAddr[p*AW +: AW];
            ed = (a == 0) ? '0 : m_reg[a];
            eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef PIPE_REG_FILE_BYPASS_EN
            if (rstN && wrEn && wrAddr != 0 && a == wrAddr) begin
               ed = wrData;
               eb = issueEn && issueAddr == wrAddr;
            end
`endif
            check($sformatf("cyc_rdData%0d", p), 64'(rdData[p*W +: W]), 64'(ed));
            check($sformatf("cyc_rdBusy%0d", p), 64'(rdBusy[p]), 64'(eb));
         end
         check("cyc_busyCnt", 64'(busyCnt), 64'(model_count()));
         check("cyc_anyBusy", 64'(anyBusy), 64'(model_count() != 0));
      end
   end

   task automatic idle();
      wrEn = 1'b0; wrAddr = '0; wrData = '0;
      issueEn = 1'b0; issueAddr = '0;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      rdAddr[p*AW +: AW] = a;
   endtask

   task automatic set_all_rd(input logic [AW-1:0] a);
      for (int p = 0; p < NR; p++) rdAddr[p*AW +: AW] = a;
   endtask

   // Advance past the next rising edge; inputs then change 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstN = 1'b0;
      rdAddr = '0;
      idle();
      #3;
      set_all_rd(5'd5);
      #1;
      check("reset_rdData", 64'(rdData), 64'(0));
      check("reset_rdBusy", 64'(rdBusy), 64'(0));
      check("reset_busyCnt", 64'(busyCnt), 64'(0));
      check("reset_anyBusy", 64'(anyBusy), 64'(0));
      #3 rstN = 1'b1;
      cmp_en = 1'b1;
      tick();

      // Load reg5 and reserve reg6, then reset mid-cycle.
      wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'hDEADBEEF;
      issueEn = 1'b1; issueAddr = 5'd6;
      tick();
      idle();
      #1;
      check("load_reg5", 64'(rdData[0 +: W]), 64'hDEADBEEF);
      check("load_busyCnt", 64'(busyCnt), 64'd1);
      rstN = 1'b0;
      #1;
      check("midrst_reg5", 64'(rdData[0 +: W]), 64'd0);
      check("midrst_busyCnt", 64'(busyCnt), 64'd0);
      check("midrst_anyBusy", 64'(anyBusy), 64'd0);
      #1 rstN = 1'b1;
      tick();

      // Register 0 ignores writes and issues.
      set_all_rd(5'd0);
      wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'h12345678;
      issueEn = 1'b1; issueAddr = 5'd0;
      tick();
      idle();
      #1;
      check("zero_rdData", 64'(rdData), 64'd0);
      check("zero_rdBusy", 64'(rdBusy), 64'd0);
      check("zero_busyCnt", 64'(busyCnt), 64'd0);

      // Scoreboard: reserve 3 and 7, then retire 3.
      set_rd(0, 5'd3); set_rd(1, 5'd7);
      issueEn = 1'b1; issueAddr = 5'd3;
      tick();
      issueAddr = 5'd7;
      tick();
      idle();
      #1;
      check("sb_busyCnt2", 64'(busyCnt), 64'd2);
      check("sb_busy3", 64'(rdBusy[0]), 64'd1);
      wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hA5A5A5A5;
      tick();
      idle();
      #1;
      check("sb_rdBusy3", 64'(rdBusy[0]), 64'd0);
      check("sb_rdData3", 64'(rdData[0 +: W]), 64'hA5A5A5A5);
      check("sb_busyCnt1", 64'(busyCnt), 64'd1);

      // Same-edge issue and write to busy register 9.
      set_rd(0, 5'd9); set_rd(1, 5'd4);
      issueEn = 1'b1; issueAddr = 5'd9;
      tick();
      wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h55;
      tick();
      idle();
      #1;
      check("same_rdData9", 64'(rdData[0 +: W]), 64'h55);
      check("same_rdBusy9", 64'(rdBusy[0]), 64'd1);
      check("same_busyCnt", 64'(busyCnt), 64'd2);

      // Same edge: issue 4, retire 9.
      issueEn = 1'b1; issueAddr = 5'd4;
      wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h66;
      tick();
      idle();
      #1;
      check("two_busyCnt", 64'(busyCnt), 64'd2);
      check("two_busy9", 64'(rdBusy[0]), 64'd0);
      check("two_busy4", 64'(rdBusy[1]), 64'd1);

      // Bypass: every port reads 12 while it is rewritten.
      set_all_rd(5'd12);
      wrEn = 1'b1; wrAddr = 5'd12; wrData = 32'h11112222;
      tick();
      wrData = 32'hCAFE0001;
      #1;
      for (int p = 0; p < NR; p++) begin
`ifdef PIPE_REG_FILE_BYPASS_EN
         check($sformatf("byp_same%0d", p), 64'(rdData[p*W +: W]), 64'hCAFE0001);
`else
         check($sformatf("byp_same%0d", p), 64'(rdData[p*W +: W]), 64'h11112222);
`endif
      end
      tick();
      idle();
      #1;
      for (int p = 0; p < NR; p++)
         check($sformatf("byp_next%0d", p), 64'(rdData[p*W +: W]), 64'hCAFE0001);

      // Randomized traffic, biased towards a few registers for collisions.
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < NR; p++)
            set_rd(p, ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom));
         wrEn      = ($urandom_range(0, 2) != 0);
         wrAddr    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wrData    = $urandom;
         issueEn   = ($urandom_range(0, 2) != 0);
         issueAddr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            #1 rstN = 1'b0;
            #1;
            check("rnd_rst_busyCnt", 64'(busyCnt), 64'd0);
            rstN = 1'b1;
         end
         tick();
      end
      idle();
      tick();
      cmp_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
